// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the mini CPU datapath.
// Moore outputs are decoded from the registered state and the current IR fields.
module control_unit (
  input  logic        Clock,
  input  logic        clear,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  op,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0]  state_r;
  logic [3:0]  state_nxt_s;
  logic [3:0]  end_state_s;
  logic        t1_wait_r;
  logic        illegal_r;
  logic [4:0]  opc_s;
  logic [15:0] ra_hot_s;
  logic [15:0] rb_hot_s;
  logic [15:0] rc_hot_s;
  logic        is_alu3_s;
  logic        is_muldiv_s;
  logic        is_unary_s;
  logic        is_nop_s;
  logic        is_halt_s;
  logic        is_legal_s;
  logic        unused_ir_s;

  function automatic logic [15:0] one_hot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  assign opc_s       = IR[31:27];
  assign ra_hot_s    = one_hot16(IR[26:23]);
  assign rb_hot_s    = one_hot16(IR[22:19]);
  assign rc_hot_s    = one_hot16(IR[18:15]);
  assign unused_ir_s = ^IR[14:0];
  assign end_state_s = run ? S_T0 : S_IDLE;

  // Opcode class decode
  always_comb begin
    is_alu3_s   = 1'b0;
    is_muldiv_s = 1'b0;
    is_unary_s  = 1'b0;
    is_nop_s    = 1'b0;
    is_halt_s   = 1'b0;
    case (opc_s)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: is_alu3_s   = 1'b1;
      5'b01111, 5'b10000:                     is_muldiv_s = 1'b1;
      5'b10001, 5'b10010:                     is_unary_s  = 1'b1;
      5'b11010:                               is_nop_s    = 1'b1;
      5'b11011:                               is_halt_s   = 1'b1;
      default:                                is_nop_s    = 1'b0;
    endcase
  end

  assign is_legal_s = is_alu3_s | is_muldiv_s | is_unary_s | is_nop_s | is_halt_s;

  // Next-state logic; run is consulted only in IDLE and on an instruction's last state
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: state_nxt_s = end_state_s;
      S_T0:   state_nxt_s = S_T1;
      S_T1:   state_nxt_s = mem_ready ? S_T2 : S_T1;
      S_T2: begin
        if (is_halt_s) begin
          state_nxt_s = S_HALT;
        end else if (is_alu3_s || is_muldiv_s || is_unary_s) begin
          state_nxt_s = S_T3;
        end else begin
          state_nxt_s = end_state_s;
        end
      end
      S_T3:   state_nxt_s = S_T4;
      S_T4:   state_nxt_s = (is_alu3_s || is_muldiv_s) ? S_T5 : end_state_s;
      S_T5:   state_nxt_s = is_muldiv_s ? S_T6 : end_state_s;
      S_T6:   state_nxt_s = end_state_s;
      S_HALT: state_nxt_s = S_HALT;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register, first-T1 tracker and sticky illegal flag
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_r   <= S_IDLE;
      t1_wait_r <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      t1_wait_r <= (state_r == S_T1);
      illegal_r <= illegal_r | ((state_r == S_T2) && !is_legal_s);
    end
  end

  // Output decode from registered state and IR fields
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rout     = 16'h0000;
    Rin      = 16'h0000;
    op       = 5'b00000;
    halted   = 1'b0;
    illegal  = illegal_r;
    case (state_r)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = !t1_wait_r;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu3_s) begin
          Rout = rb_hot_s;
          Yin  = 1'b1;
        end else if (is_muldiv_s) begin
          Rout = ra_hot_s;
          Yin  = 1'b1;
        end else if (is_unary_s) begin
          Rout = rb_hot_s;
          Zin  = 1'b1;
          op   = opc_s;
        end else begin
          Rout = 16'h0000;
        end
      end
      S_T4: begin
        if (is_alu3_s || is_muldiv_s) begin
          Rout = is_alu3_s ? rc_hot_s : rb_hot_s;
          Zin  = 1'b1;
          op   = opc_s;
        end else if (is_unary_s) begin
          Zlowout = 1'b1;
          Rin     = ra_hot_s;
        end else begin
          Rout = 16'h0000;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv_s) begin
          LOin = 1'b1;
        end else begin
          Rin = ra_hot_s;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule
